// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, port ids and default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    // Wide enough for ACC_CYCLES-1 with ACC_CYCLES up to 7.
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: round-robin on ties, or strict CPU priority when prio_mode=1.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    input  logic       prio_mode,
    output port_id_t   gnt_id,
    output logic       any
);

    // req[0] is the CPU, req[1] the debug port. A tie goes to whoever did not win last time.
    always_comb begin
        any    = |req;
        gnt_id = PORT_CPU;
        if (req == 2'b10) begin
            gnt_id = PORT_DBG;
        end else if (req == 2'b11 && !prio_mode && last == PORT_CPU) begin
            gnt_id = PORT_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM between the CPU and debug ports; sequences strobes and returns a one-cycle ack.
// Optional build macro MEM_ARB_CPU_PRIO_EN: CPU has strict priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              grant_dbg
);

`ifdef MEM_ARB_CPU_PRIO_EN
    localparam logic PRIO_MODE = 1'b1;
`else
    localparam logic PRIO_MODE = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    port_id_t          last_grant;
    port_id_t          gnt_id;
    logic              any_req;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              last_cycle;

    rr_arb2 u_pick (
        .req       ({dbg_req, cpu_req}),
        .last      (last_grant),
        .prio_mode (PRIO_MODE),
        .gnt_id    (gnt_id),
        .any       (any_req)
    );

    assign last_cycle = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        cpu_ack    = 1'b0;
        dbg_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ACCESS;
            end
            ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = we_r;
                sram_we_n  = !we_r;
                sram_dq_oe = we_r;
                if (cnt == '0) state_nxt = ACK;
            end
            ACK: begin
                // Data bus stays driven one extra cycle after WE# rises for hold time.
                sram_dq_oe = we_r;
                cpu_ack    = (last_grant == PORT_CPU);
                dbg_ack    = (last_grant == PORT_DBG);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt         <= '0;
            last_grant  <= PORT_DBG;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            cpu_rdata_r <= '0;
            dbg_rdata_r <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last_grant <= gnt_id;
                cnt        <= CNT_LOAD;
                if (gnt_id == PORT_DBG) begin
                    we_r    <= dbg_we;
                    addr_r  <= dbg_addr;
                    wdata_r <= dbg_wdata;
                end else begin
                    we_r    <= cpu_we;
                    addr_r  <= cpu_addr;
                    wdata_r <= cpu_wdata;
                end
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (last_cycle && !we_r) begin
                if (last_grant == PORT_DBG) dbg_rdata_r <= sram_dq_in;
                else                        cpu_rdata_r <= sram_dq_in;
            end
        end
    end

    assign sram_addr   = addr_r;
    assign sram_dq_out = wdata_r;
    assign cpu_rdata   = cpu_rdata_r;
    assign dbg_rdata   = dbg_rdata_r;
    assign busy        = (state != IDLE);
    assign grant_dbg   = (last_grant == PORT_DBG);

endmodule
